// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit common-anode seven-segment scanner with frame latch and leading-zero blanking
//
// Purpose: time-multiplexes a 16-bit display word across four digits. Each
// digit stays lit for REFRESH_COUNT cycles. The display content is latched once
// per frame so that a frame never shows a mix of old and new digits.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   digits_in  [15:0] display word, [3:0] = digit 0 (rightmost)
//   dp_in      [3:0]  decimal point request per digit, 1 = lit
//   blank_lz   1 = blank leading zeros
//   an         [3:0]  anode enables, active-low, an[k] drives digit k
//   seg        [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
module seven_seg_scanner #(
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(REFRESH_COUNT - 1);

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_digits_q, sh_digits_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          sh_blank_q, sh_blank_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [3:0]    nibble;
  logic          blank_slot;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    an_d        = 4'b1111;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    blank_slot  = 1'b0;

    tick = (count_q == COUNT_LAST);

    if (tick) begin
      count_d = '0;
      idx_d   = idx_q + 2'd1;
      // Frame boundary: the only edge where new content is accepted.
      if (idx_q == 2'd3) begin
        sh_digits_d = digits_in;
        sh_dp_d     = dp_in;
        sh_blank_d  = blank_lz;
      end
    end else begin
      count_d = count_q + CW'(1);
    end

    nibble = sh_digits_q[{idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    case (idx_q)
      2'd3:    blank_slot = sh_blank_q && (sh_digits_q[15:12] == 4'h0);
      2'd2:    blank_slot = sh_blank_q && (sh_digits_q[15:8] == 8'h00);
      2'd1:    blank_slot = sh_blank_q && (sh_digits_q[15:4] == 12'h000);
      default: blank_slot = 1'b0;
    endcase

    if (!blank_slot) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nibble);
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      idx_q       <= 2'd0;
      sh_digits_q <= 16'h0000;
      sh_dp_q     <= 4'h0;
      sh_blank_q  <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the switch logic stage and consumes its 16-bit display word, four 4-bit nibbles that are either hex or BCD digits (including the 16'hE000 overflow code). Each nibble is decoded to active-low segments and the anodes are scanned at a parameterised refresh rate. Input content is latched once per scan frame so that no digit tears mid-frame, and optional leading-zero blanking is supported.

## Interface
- REFRESH_COUNT, 100000, clk cycles each digit stays lit (1 ms at 100 MHz, 250 Hz frame); legal range ≥ 2.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- digits_in  input  16  display word; [3:0] is the rightmost digit (digit 0), [15:12] is the leftmost (digit 3).
- dp_in  input  4  decimal point request per digit; bit k controls digit k; 1 = lit.
- blank_lz  input  1  1 = blank leading zeros.
- an  output  4  anode enables, active-low; an[k] drives digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- **Refresh counter.**
  - Counts 0..REFRESH_COUNT-1, then wraps to 0.
  - tick = (count == REFRESH_COUNT-1).
- **Digit index.**
  - 2-bit idx advances 0→1→2→3→0 on tick.
- **Frame latch.**
  - Shadow registers capture {digits_in, dp_in, blank_lz} on the edge where tick is high and idx == 3. That is the same edge where idx wraps to 0.
  - No other edge updates the shadows.
- **Leading-zero blanking.**
  - Applies only when shadow blank_lz = 1.
  - Digit k (k = 3, 2, 1) is blanked when its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - Internal zeros stay lit, e.g. 0x0105 shows "105".
- **Blanked digit.** In that digit's slot: an = 4'b1111, seg = 7'h7F, dp = 1.
- **Decode (gfedcba, active-low).**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Non-blanked slot outputs.**
  - an has only bit idx low.
  - seg = decode(shadow nibble idx).
  - dp = ~shadow dp[idx].
- **Reset.**
  - Outputs: an = 4'b1111, seg = 7'h7F, dp = 1.
  - Internal state: count = 0, idx = 0, all shadows = 0.
  - Reset mid-scan aborts the frame; the first post-reset frame displays the zeroed shadows.
- **Register boundary.** All outputs are registered; there is no combinational path from any input to any output.

## Timing
- **Output lag.** Outputs are registered from the current idx and shadows, so they lag idx by 1 cycle.
- **First cycle after reset release.** an = 1110, seg = 1000000 ("0"), dp = 1.
- **Slot length.** Each digit slot lasts exactly REFRESH_COUNT cycles; a frame is 4·REFRESH_COUNT cycles.
- **Input-to-display latency.**
  - A digits_in change is displayed starting 1 cycle after the next frame boundary.
  - Worst case is 4·REFRESH_COUNT + 1 cycles.
- **Simultaneous events.** reset has priority over tick and over the shadow load.
- **Input sampling.** Inputs are sampled only at the frame-boundary edge; glitches at any other time are invisible.

## Test plan
All scenarios use REFRESH_COUNT = 4.
- **Reset values.** Hold reset 3 cycles → an = 1111, seg = 7F, dp = 1 throughout. Release → next cycle an = 1110, seg = 1000000.
- **Scan order.** digits_in = 16'h1234, wait one frame boundary → repeating pattern of 4 cycles each:
  - an 1110 / seg 0011001
  - an 1101 / seg 0110000
  - an 1011 / seg 0100100
  - an 0111 / seg 1111001
- **Frame latch.** Change digits_in from 16'h1234 to 16'hABCD while idx = 1 → remaining slots still show 3, 2, 1. "ABCD" appears starting 1 cycle after the next wrap to idx 0.
- **Blanking.** blank_lz = 1:
  - 16'h0005 → only the an = 1110 slot is active, showing "5"; the other slots have an = 1111.
  - 16'h0000 → digit 0 shows "0".
  - 16'h0105 → digits 2, 1, 0 show 1, 0, 5.
- **Overflow code and decimal point.** digits_in = 16'hE000, blank_lz = 1, dp_in = 4'b0100:
  - digit 3 shows seg 0000110; digits 2..0 show 1000000.
  - dp = 0 only in the digit 2 slot.
- **Reset mid-scan.** Assert reset during the idx = 2 slot → next edge gives reset outputs. After release, scanning restarts at digit 0 with shadows = 0.
